clkdiv_sync: RTL

- Parametrised, fully synchronous successor to the ripple clock divider.
- Generates NCH independent clock-enable strobes from one system clock. No derived clocks are produced.
- Each channel has a runtime-programmable divisor and can optionally cascade off the previous channel, giving ripple-style chained division.
- Feeds the modulation, sample, ADSR and multiplier enable inputs of the synth datapath.

---
 rtl/clkdiv_sync.sv | 106 ++++++++++
 1 files changed

// File: rtl/clkdiv_sync.sv
// clkdiv_sync: NCH independent clock-enable strobe generators driven by one system clock.
// No derived clocks are produced. Each channel has a runtime-programmable divisor and can
// optionally cascade off the strobe of the previous channel for chained division.
// Latency: tick_o is registered, so it is high in the cycle after the edge where the channel reloaded.
// Backpressure: none; en freezes every counter and sync realigns all channels to count 0.
// Optional feature macro: CLKDIV_SYNC_PHASE_EN adds 50% duty phase_o toggles; otherwise phase_o is tied to 0.
// Ports:
//   clk, rst (synchronous, active-high), en (global count enable), sync (realign request),
//   div_i (NCH*DIVW packed divisors), div_load (per-channel divisor capture), casc (cascade select,
//   bit 0 ignored), tick_o (one-cycle strobes), phase_o (toggle outputs).
module clkdiv_sync #(
  parameter int NCH     = 4,
  parameter int DIVW    = 16,
  parameter int DIV_RST = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic [NCH*DIVW-1:0]  div_i,
  input  logic [NCH-1:0]       div_load,
  input  logic [NCH-1:0]       casc,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       phase_o
);

  logic [DIVW-1:0] r_div [NCH];
  logic [DIVW-1:0] r_cnt [NCH];
  logic [NCH-1:0]  r_tick;
  logic [NCH-1:0]  w_adv;
  logic [NCH-1:0]  w_stb;

  // The strobe ripples combinationally from channel 0 upward: a cascaded channel only
  // advances in the same cycle its predecessor reloads. The chain is carried in a local
  // variable so each output bit is written but never read back inside this block.
  always_comb begin
    logic v_carry;
    logic v_adv;
    logic v_stb;
    w_adv   = '0;
    w_stb   = '0;
    v_carry = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      v_adv    = en & ((i == 0) | ~casc[i] | v_carry);
      v_stb    = v_adv & (r_cnt[i] == '0);
      w_adv[i] = v_adv;
      w_stb[i] = v_stb;
      v_carry  = v_stb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_div[i] <= DIVW'(DIV_RST);
        r_cnt[i] <= '0;
      end
      r_tick <= '0;
    end else begin
      // A load only replaces the divisor; the count in flight is untouched, so the new
      // value first applies at the following reload (a same-edge reload sees the old value).
      for (int i = 0; i < NCH; i++) begin
        if (div_load[i]) begin
          r_div[i] <= div_i[i*DIVW +: DIVW];
        end
      end
      if (sync) begin
        for (int i = 0; i < NCH; i++) begin
          r_cnt[i] <= '0;
        end
        r_tick <= '0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (w_stb[i]) begin
            r_cnt[i]  <= r_div[i];
            r_tick[i] <= 1'b1;
          end else if (w_adv[i]) begin
            r_cnt[i]  <= r_cnt[i] - DIVW'(1);
            r_tick[i] <= 1'b0;
          end else begin
            r_tick[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign tick_o = r_tick;

`ifdef CLKDIV_SYNC_PHASE_EN
  logic [NCH-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (rst || sync) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase ^ w_stb;
    end
  end

  assign phase_o = r_phase;
`else
  assign phase_o = '0;
`endif

endmodule
